// File: rtl/regfile_scan_if.sv
// Port bundle for regfile_scan: write port, two bypassed read ports, debug read port and scan stream.
interface regfile_scan_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] ra_debug;
  logic [DATA_W-1:0] ra_debug_data;

  // Scan stream handshake: a beat (dump_addr, dump_data) transfers on every cycle with
  // dump_valid && dump_ready. dump_valid stays high until its beat transfers (reset excepted);
  // dump_addr is stable while stalled, dump_data tracks live writes to that register.
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;
  logic [2:0]        dump_state;

  modport master (
    output we3, wa3, wd3, ra1, ra2, ra_debug, dump_start, dump_ready,
    input  rd1, rd2, ra_debug_data, dump_valid, dump_addr, dump_data,
           dump_busy, dump_done, dump_state
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, ra_debug, dump_start, dump_ready,
    output rd1, rd2, ra_debug_data, dump_valid, dump_addr, dump_data,
           dump_busy, dump_done, dump_state
  );
endinterface

// File: rtl/regfile_scan.sv
// Register file with same-cycle write bypass, async clear and a handshaked full-contents scan engine.
module regfile_scan #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_scan_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    DONE = 3'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DATA_W-1:0] rf [DEPTH];

  // Shared by rd1, rd2 and the scan beat: zero rule first, then bypass, then storage.
  function automatic logic [DATA_W-1:0] port_read(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (ZERO_REG != 0 && a == '0) return '0;
    else if (we && wa == a)       return wd;
    else                          return stored;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (bus.we3 && !(ZERO_REG != 0 && bus.wa3 == '0)) begin
      rf[bus.wa3] <= bus.wd3;
    end
  end

  assign bus.rd1 = port_read(bus.ra1, rf[bus.ra1], bus.we3, bus.wa3, bus.wd3);
  assign bus.rd2 = port_read(bus.ra2, rf[bus.ra2], bus.we3, bus.wa3, bus.wd3);
  assign bus.ra_debug_data = (ZERO_REG != 0 && bus.ra_debug == '0) ? '0 : rf[bus.ra_debug];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Termination is the all-ones compare on idx, so idx never has to wrap.
  always_comb begin
    state_n        = state;
    idx_n          = idx;
    bus.dump_valid = 1'b0;
    bus.dump_addr  = '0;
    bus.dump_data  = '0;
    bus.dump_busy  = 1'b0;
    bus.dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dump_start) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        bus.dump_valid = 1'b1;
        bus.dump_busy  = 1'b1;
        bus.dump_addr  = idx;
        bus.dump_data  = port_read(idx, rf[idx], bus.we3, bus.wa3, bus.wd3);
        if (bus.dump_ready) begin
          if (&idx) state_n = DONE;
          else      idx_n   = idx + 1'b1;
        end
      end
      DONE: begin
        bus.dump_busy = 1'b1;
        bus.dump_done = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dump_state = state;
endmodule

// File: tb/tb_regfile_scan.sv
// Self-checking bench for regfile_scan: a 32x32 ZERO_REG=1 instance and a 8x16 ZERO_REG=0 instance.
module tb_regfile_scan;
  localparam int DW_A = 32, AW_A = 5, DEPTH_A = 32;
  localparam int DW_B = 16, AW_B = 3, DEPTH_B = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scan_if #(.DATA_W(DW_A), .ADDR_W(AW_A)) bus_a ();
  regfile_scan_if #(.DATA_W(DW_B), .ADDR_W(AW_B)) bus_b ();

  regfile_scan #(.DATA_W(DW_A), .ADDR_W(AW_A), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  regfile_scan #(.DATA_W(DW_B), .ADDR_W(AW_B), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW_A-1:0] mem_a [DEPTH_A];
  logic [DW_B-1:0] mem_b [DEPTH_B];
  logic [AW_A-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW_A-1:0] ref_a(input int a, input bit bypass);
    if (a == 0) return '0;
    if (bypass && bus_a.we3 && int'(bus_a.wa3) == a) return bus_a.wd3;
    return mem_a[a];
  endfunction

  function automatic logic [DW_B-1:0] ref_b(input int a, input bit bypass);
    if (bypass && bus_b.we3 && int'(bus_b.wa3) == a) return bus_b.wd3;
    return mem_b[a];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
    for (int i = 0; i < DEPTH_B; i++) mem_b[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus_a.we3 = 1'b0; bus_a.wa3 = '0; bus_a.wd3 = '0; bus_a.ra1 = '0; bus_a.ra2 = '0;
    bus_a.ra_debug = '0; bus_a.dump_start = 1'b0; bus_a.dump_ready = 1'b0;
    bus_b.we3 = 1'b0; bus_b.wa3 = '0; bus_b.wd3 = '0; bus_b.ra1 = '0; bus_b.ra2 = '0;
    bus_b.ra_debug = '0; bus_b.dump_start = 1'b0; bus_b.dump_ready = 1'b0;
  endtask

  // Inputs are driven in the low phase; the model commits writes at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus_a.we3 && bus_a.wa3 != '0) mem_a[bus_a.wa3] = bus_a.wd3;
      if (bus_b.we3) mem_b[bus_b.wa3] = bus_b.wd3;
    end
    @(negedge clk);
  endtask

  task automatic check_dump_idle_a(input string tag);
    check({tag, "_valid"}, 64'(bus_a.dump_valid), 64'd0);
    check({tag, "_busy"},  64'(bus_a.dump_busy),  64'd0);
    check({tag, "_done"},  64'(bus_a.dump_done),  64'd0);
    check({tag, "_addr"},  64'(bus_a.dump_addr),  64'd0);
    check({tag, "_data"},  64'(bus_a.dump_data),  64'd0);
  endtask

  // Full scan on instance A against the address queue; beat data is the model value at transfer time.
  task automatic scan_a(input bit rnd);
    int budget;
    exp_q.delete();
    for (int k = 0; k < DEPTH_A; k++) exp_q.push_back(AW_A'(k));
    idle_inputs();
    bus_a.dump_start = 1'b1;
    bus_a.dump_ready = 1'b1;
    tick();
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      budget++;
      bus_a.dump_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus_a.we3        = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_a.wa3        = ($urandom_range(0, 1) != 0) ? exp_q[0] : AW_A'($urandom_range(0, DEPTH_A - 1));
      bus_a.wd3        = $urandom;
      bus_a.dump_start = rnd && ($urandom_range(0, 5) == 0);
      #1;
      check("scan_valid", 64'(bus_a.dump_valid), 64'd1);
      check("scan_busy",  64'(bus_a.dump_busy),  64'd1);
      check("scan_addr",  64'(bus_a.dump_addr),  64'(exp_q[0]));
      check("scan_data",  64'(bus_a.dump_data),  64'(ref_a(int'(exp_q[0]), 1'b1)));
      if (bus_a.dump_ready) void'(exp_q.pop_front());
      tick();
    end
    check("scan_budget", 64'(exp_q.size()), 64'd0);
    idle_inputs();
    bus_a.dump_start = 1'b1;
    #1;
    check("scan_done_pulse", 64'(bus_a.dump_done),  64'd1);
    check("scan_done_busy",  64'(bus_a.dump_busy),  64'd1);
    check("scan_done_valid", 64'(bus_a.dump_valid), 64'd0);
    tick();
    bus_a.dump_start = 1'b0;
    #1;
    check("scan_after_done", 64'(bus_a.dump_done), 64'd0);
    check("scan_no_restart", 64'(bus_a.dump_busy), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic            we;
    logic [AW_A-1:0] wa;
    logic [DW_A-1:0] wd;
    logic [AW_A-1:0] ra1, ra2, rdbg;
    logic [DW_A-1:0] e1, e2, edbg;
  } vec_t;
  vec_t vecs [7];

  int busy_cycles;

  initial begin
    vecs[0] = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd0,  5'd7,  32'h11,       32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h11};
    vecs[2] = '{1'b1, 5'd0,  32'h55,       5'd0,  5'd7,  5'd0,  32'h0,        32'h22,       32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h99,       5'd0,  5'd7,  5'd0,  32'h0,        32'h22,       32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd30, 5'd31, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd31, 32'h1,        5'd31, 5'd7,  5'd31, 32'hDEADBEEF, 32'h22,       32'hDEADBEEF};
    vecs[6] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};

    idle_inputs();
    clear_models();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_a.ra1 = 5'd3;
    #1;
    check_dump_idle_a("reset");
    check("reset_rd1", 64'(bus_a.rd1), 64'd0);
    check("reset_dbg", 64'(bus_a.ra_debug_data), 64'd0);
    check("reset_b_rd1", 64'(bus_b.rd1), 64'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      bus_a.we3 = vecs[i].we;   bus_a.wa3 = vecs[i].wa;   bus_a.wd3 = vecs[i].wd;
      bus_a.ra1 = vecs[i].ra1;  bus_a.ra2 = vecs[i].ra2;  bus_a.ra_debug = vecs[i].rdbg;
      #1;
      check("vec_rd1", 64'(bus_a.rd1), 64'(vecs[i].e1));
      check("vec_rd2", 64'(bus_a.rd2), 64'(vecs[i].e2));
      check("vec_dbg", 64'(bus_a.ra_debug_data), 64'(vecs[i].edbg));
      tick();
    end

    // Asynchronous clear, asserted in the middle of the low phase.
    idle_inputs();
    bus_a.ra1 = 5'd5;
    bus_a.ra_debug = 5'd5;
    #1;
    check("pre_clear_rd1", 64'(bus_a.rd1), 64'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("clear_rd1", 64'(bus_a.rd1), 64'd0);
    check("clear_dbg", 64'(bus_a.ra_debug_data), 64'd0);
    check_dump_idle_a("clear");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_models();

    // Instance B, ZERO_REG=0: r0 is ordinary storage.
    bus_b.we3 = 1'b1; bus_b.wa3 = '0; bus_b.wd3 = 16'h55; bus_b.ra1 = '0; bus_b.ra_debug = '0;
    #1;
    check("b_r0_bypass", 64'(bus_b.rd1), 64'h55);
    check("b_r0_dbg_nobypass", 64'(bus_b.ra_debug_data), 64'h0);
    tick();
    bus_b.we3 = 1'b0;
    #1;
    check("b_r0_stored", 64'(bus_b.rd1), 64'h55);
    check("b_r0_dbg", 64'(bus_b.ra_debug_data), 64'h55);

    // Random read/write traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      bus_a.we3 = 1'($urandom_range(0, 1));
      bus_a.wa3 = AW_A'($urandom_range(0, DEPTH_A - 1));
      bus_a.wd3 = $urandom;
      bus_a.ra1 = ($urandom_range(0, 3) == 0) ? bus_a.wa3 : AW_A'($urandom_range(0, DEPTH_A - 1));
      bus_a.ra2 = ($urandom_range(0, 3) == 0) ? bus_a.wa3 : AW_A'($urandom_range(0, DEPTH_A - 1));
      bus_a.ra_debug = AW_A'($urandom_range(0, DEPTH_A - 1));
      bus_b.we3 = 1'($urandom_range(0, 1));
      bus_b.wa3 = AW_B'($urandom_range(0, DEPTH_B - 1));
      bus_b.wd3 = 16'($urandom);
      bus_b.ra1 = ($urandom_range(0, 3) == 0) ? bus_b.wa3 : AW_B'($urandom_range(0, DEPTH_B - 1));
      bus_b.ra2 = AW_B'($urandom_range(0, DEPTH_B - 1));
      bus_b.ra_debug = bus_b.wa3;
      #1;
      check("rnd_a_rd1", 64'(bus_a.rd1), 64'(ref_a(int'(bus_a.ra1), 1'b1)));
      check("rnd_a_rd2", 64'(bus_a.rd2), 64'(ref_a(int'(bus_a.ra2), 1'b1)));
      check("rnd_a_dbg", 64'(bus_a.ra_debug_data), 64'(ref_a(int'(bus_a.ra_debug), 1'b0)));
      check("rnd_b_rd1", 64'(bus_b.rd1), 64'(ref_b(int'(bus_b.ra1), 1'b1)));
      check("rnd_b_rd2", 64'(bus_b.rd2), 64'(ref_b(int'(bus_b.ra2), 1'b1)));
      check("rnd_b_dbg", 64'(bus_b.ra_debug_data), 64'(ref_b(int'(bus_b.ra_debug), 1'b0)));
      tick();
    end

    // Full scan with dump_ready held high: rK = K*0x10.
    idle_inputs();
    for (int k = 0; k < DEPTH_A; k++) begin
      bus_a.we3 = 1'b1; bus_a.wa3 = AW_A'(k); bus_a.wd3 = DW_A'(k * 16);
      tick();
    end
    idle_inputs();
    bus_a.dump_ready = 1'b1;
    bus_a.dump_start = 1'b1;
    #1;
    check("full_start_cycle_valid", 64'(bus_a.dump_valid), 64'd0);
    tick();
    bus_a.dump_start = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 36; c++) begin
      #1;
      if (bus_a.dump_busy) busy_cycles++;
      if (c < DEPTH_A) begin
        check("full_valid", 64'(bus_a.dump_valid), 64'd1);
        check("full_addr",  64'(bus_a.dump_addr),  64'(c));
        check("full_data",  64'(bus_a.dump_data),  64'(c * 16));
        check("full_done_early", 64'(bus_a.dump_done), 64'd0);
      end else if (c == DEPTH_A) begin
        check("full_done", 64'(bus_a.dump_done), 64'd1);
        check("full_done_valid", 64'(bus_a.dump_valid), 64'd0);
        check("full_done_data", 64'(bus_a.dump_data), 64'd0);
      end else begin
        check("full_idle_done", 64'(bus_a.dump_done), 64'd0);
      end
      tick();
    end
    check("full_busy_cycles", 64'(busy_cycles), 64'd33);

    // Pseudo-random backpressure, live writes and ignored restarts.
    scan_a(1'b1);
    scan_a(1'b1);

    // Reset in the middle of a scan, at beat 10.
    idle_inputs();
    bus_a.dump_ready = 1'b1;
    bus_a.dump_start = 1'b1;
    tick();
    bus_a.dump_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    bus_a.ra1 = 5'd10;
    #1;
    check("abort_addr", 64'(bus_a.dump_addr), 64'd10);
    check("abort_valid_before", 64'(bus_a.dump_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_dump_idle_a("abort");
    check("abort_rd1", 64'(bus_a.rd1), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_models();
    #1;
    check("abort_no_done", 64'(bus_a.dump_done), 64'd0);
    tick();
    #1;
    check("abort_no_done_late", 64'(bus_a.dump_done), 64'd0);
    scan_a(1'b0);

    // Instance B scan: 8 beats, ends at addr 7 without wrapping.
    idle_inputs();
    for (int k = 0; k < DEPTH_B; k++) begin
      bus_b.we3 = 1'b1; bus_b.wa3 = AW_B'(k); bus_b.wd3 = DW_B'(16'h100 + k);
      tick();
    end
    idle_inputs();
    bus_b.dump_ready = 1'b1;
    bus_b.dump_start = 1'b1;
    tick();
    bus_b.dump_start = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 11; c++) begin
      #1;
      if (bus_b.dump_busy) busy_cycles++;
      if (c < DEPTH_B) begin
        check("b_scan_valid", 64'(bus_b.dump_valid), 64'd1);
        check("b_scan_addr",  64'(bus_b.dump_addr),  64'(c));
        check("b_scan_data",  64'(bus_b.dump_data),  64'(16'h100 + c));
      end else if (c == DEPTH_B) begin
        check("b_scan_done",  64'(bus_b.dump_done),  64'd1);
        check("b_scan_done_valid", 64'(bus_b.dump_valid), 64'd0);
      end else begin
        check("b_scan_no_wrap", 64'(bus_b.dump_valid), 64'd0);
      end
      tick();
    end
    check("b_busy_cycles", 64'(busy_cycles), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scan.md
# regfile_scan

Parametrised general-purpose register file for the single-cycle datapath: one synchronous write port, two combinational read ports with same-cycle write bypass, and a combinational debug read port. It adds an asynchronous clear of every register and a handshaked scan engine that streams the whole register contents, one register per beat, to the debug/trace logic. It replaces the fixed 32x32 register file in the CPU core.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary storage

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we3  in  1  write enable
- wa3  in  ADDR_W  write address
- wd3  in  DATA_W  write data
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data, combinational
- ra_debug  in  ADDR_W  debug read address
- ra_debug_data  out  DATA_W  debug read data, combinational, no bypass
- dump_start  in  1  request a full-register scan
- dump_ready  in  1  consumer accepts the current beat
- dump_valid  out  1  beat valid
- dump_addr  out  ADDR_W  register index of the current beat
- dump_data  out  DATA_W  register contents of the current beat
- dump_busy  out  1  scan in progress (SCAN or DONE)
- dump_done  out  1  one-cycle pulse after the last beat

## Operation
- Storage: DEPTH x DATA_W flops. rst clears all registers to 0.
- Write: at a rising edge with we3=1, rf[wa3] <= wd3. With ZERO_REG=1, a write to address 0 is dropped.
- Read rdN:
  - ZERO_REG=1 and raN=0 -> 0.
  - Otherwise, we3=1 and wa3==raN -> wd3 (bypass).
  - Otherwise -> rf[raN].
- ra_debug_data: rf[ra_debug], or 0 for address 0 when ZERO_REG=1. No bypass.
- Scan FSM, states IDLE, SCAN, DONE:
  - IDLE: dump_start=1 -> SCAN with idx=0. The 3-bit state and idx reset to IDLE and 0.
  - SCAN: dump_valid=1, dump_addr=idx, dump_data follows the rdN read rules at address idx, including bypass and the zero rule.
    - A transfer occurs on a cycle with dump_valid && dump_ready.
    - On a transfer with idx<DEPTH-1: idx <= idx+1.
    - On a transfer with idx==DEPTH-1: go to DONE.
    - Without dump_ready, idx holds and dump_data keeps tracking the live register value.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
- dump_start is ignored outside IDLE; no queuing.
- Register writes keep working during a scan. A beat reports the value visible at its transfer cycle.
- idx is ADDR_W bits wide and never wraps during a scan. Termination is by the DEPTH-1 compare.
- In IDLE and DONE: dump_valid=0, dump_addr=0, dump_data=0.

## Timing
- Reset values: dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0. rdN and ra_debug_data read 0 because storage is cleared.
- rst is asserted asynchronously: state, idx and storage clear immediately, mid-scan included. No dump_done is produced. rst deasserts cleanly relative to clk.
- Write latency: bypass makes the value visible the same cycle; it appears in storage from the next cycle.
- Scan latency: dump_start sampled high at edge N -> first beat valid in cycle N+1.
  - With dump_ready held at 1: DEPTH beats in cycles N+1..N+DEPTH, dump_done in cycle N+DEPTH+1, IDLE at cycle N+DEPTH+2.
  - dump_busy is high from N+1 through N+DEPTH+1.
- A dump_start in the DONE cycle is ignored. The earliest accepted restart is in the first IDLE cycle.

## Test plan
- Reset/clear: write 0xDEADBEEF to r5, pulse rst asynchronously (not edge-aligned) -> rd1 at ra1=5 reads 0 immediately, all dump outputs 0.
- Bypass and zero: r7=0x11, then in one cycle we3=1, wa3=7, wd3=0x22, ra1=ra2=7 -> rd1=rd2=0x22 that cycle and ra_debug_data=0x11. Write 0x55 to r0 -> rd1 at ra1=0 reads 0 (ZERO_REG=1). With ZERO_REG=0 -> 0x55.
- Full scan: load rK=K*0x10, pulse dump_start with dump_ready=1 -> 32 beats with addr 0..31 and data 0x000..0x1F0 (beat 0 = 0), dump_done one cycle later, dump_busy high for exactly 33 cycles.
- Backpressure: toggle dump_ready pseudo-randomly -> each addr delivered exactly once, in order. A write to the stalled register while stalled changes dump_data the same cycle. A second dump_start mid-scan is ignored.
- Reset mid-scan: assert rst at beat 10 -> dump_valid and dump_busy drop immediately, no dump_done. A new dump_start after reset streams from addr 0 with all data 0.
- Parametrisation: DATA_W=16, ADDR_W=3 -> 8-beat scan ending at addr 7 with no idx wrap. Write and bypass behave as above.
